// File: rtl/cpu_checker_fsm.sv
// cpu_checker_fsm
//   Character-stream parser for CPU write-back trace lines. It samples one
//   ASCII character per clock and classifies each complete line against
//       "^" TIME "@" PC ":" SP* ("$" GRF | "*" ADDR) SP* "<=" SP* DATA "#"
//   TIME and GRF are 1-4 decimal digits. PC, ADDR and DATA are exactly
//   8 lowercase hex digits. A '^' in any state restarts the parse.
//
// Ports
//   clk         : system clock, all state updates on the rising edge
//   reset       : asynchronous active-low reset (0 = IDLE, output 0)
//   char        : ASCII character sampled every rising edge
//   format_type : 0 none/invalid, 1 register record, 2 memory record;
//                 held for exactly one cycle after a valid '#'
module cpu_checker_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CARET,    // '^' seen, waiting for first TIME digit
        S_TIME,     // 1-4 TIME digits seen
        S_AT,       // '@' seen, waiting for first PC digit
        S_PC,       // 1-8 PC digits seen
        S_COLON,    // ':' seen, optional spaces before target
        S_DOLLAR,   // '$' seen, waiting for first GRF digit
        S_REG,      // 1-4 GRF digits seen
        S_STAR,     // '*' seen, waiting for first ADDR digit
        S_MEM,      // 1-8 ADDR digits seen
        S_SP2,      // spaces after target
        S_LT,       // '<' seen, '=' must follow directly
        S_EQ,       // "<=" seen, optional spaces before data
        S_DATA,     // 1-8 DATA digits seen
        S_DONE_REG,
        S_DONE_MEM
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;     // digits collected in the current field
    logic       mem_q, mem_d;     // target kind: 1 = memory, 0 = register

    logic is_dec, is_hex;

    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    // Next-state logic: every unlisted character falls back to IDLE.
    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        if (char == 8'h5e) begin               // '^' restarts from anywhere
            state_d = S_CARET;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_CARET: begin
                    if (is_dec) begin
                        state_d = S_TIME;
                        cnt_d   = 4'd1;
                    end
                end
                S_TIME: begin
                    if (is_dec && cnt_q < 4'd4) begin
                        state_d = S_TIME;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (char == 8'h40) begin          // '@'
                        state_d = S_AT;
                    end
                end
                S_AT: begin
                    if (is_hex) begin
                        state_d = S_PC;
                        cnt_d   = 4'd1;
                    end
                end
                S_PC: begin
                    if (is_hex && cnt_q < 4'd8) begin
                        state_d = S_PC;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (char == 8'h3a && cnt_q == 4'd8) begin  // ':'
                        state_d = S_COLON;
                    end
                end
                S_COLON: begin
                    if (char == 8'h20) begin
                        state_d = S_COLON;
                    end else if (char == 8'h24) begin                   // '$'
                        state_d = S_DOLLAR;
                        mem_d   = 1'b0;
                    end else if (char == 8'h2a) begin                   // '*'
                        state_d = S_STAR;
                        mem_d   = 1'b1;
                    end
                end
                S_DOLLAR: begin
                    if (is_dec) begin
                        state_d = S_REG;
                        cnt_d   = 4'd1;
                    end
                end
                S_REG: begin
                    if (is_dec && cnt_q < 4'd4) begin
                        state_d = S_REG;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (char == 8'h20) begin
                        state_d = S_SP2;
                    end else if (char == 8'h3c) begin                   // '<'
                        state_d = S_LT;
                    end
                end
                S_STAR: begin
                    if (is_hex) begin
                        state_d = S_MEM;
                        cnt_d   = 4'd1;
                    end
                end
                S_MEM: begin
                    if (is_hex && cnt_q < 4'd8) begin
                        state_d = S_MEM;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (char == 8'h20 && cnt_q == 4'd8) begin
                        state_d = S_SP2;
                    end else if (char == 8'h3c && cnt_q == 4'd8) begin
                        state_d = S_LT;
                    end
                end
                S_SP2: begin
                    if (char == 8'h20) begin
                        state_d = S_SP2;
                    end else if (char == 8'h3c) begin
                        state_d = S_LT;
                    end
                end
                S_LT: begin
                    if (char == 8'h3d) begin                            // '='
                        state_d = S_EQ;
                    end
                end
                S_EQ: begin
                    if (char == 8'h20) begin
                        state_d = S_EQ;
                    end else if (is_hex) begin
                        state_d = S_DATA;
                        cnt_d   = 4'd1;
                    end
                end
                S_DATA: begin
                    if (is_hex && cnt_q < 4'd8) begin
                        state_d = S_DATA;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (char == 8'h23 && cnt_q == 4'd8) begin  // '#'
                        state_d = mem_q ? S_DONE_MEM : S_DONE_REG;
                    end
                end
                default: state_d = S_IDLE;  // IDLE and DONE_* leave only on '^'
            endcase
        end
    end

    // Output decode (Moore)
    always_comb begin
        format_type = 2'd0;
        case (state_q)
            S_DONE_REG: format_type = 2'd1;
            S_DONE_MEM: format_type = 2'd2;
            default:    format_type = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_cpu_checker_fsm.sv
module tb_cpu_checker_fsm;

    logic       clk;
    logic       reset;
    logic [7:0] char_in;
    logic [1:0] format_type;

    int unsigned total;
    int unsigned bad;

    // Scoreboard: one expected output per driven character.
    logic [1:0] exp_q[$];
    string      name_q[$];

    cpu_checker_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .char       (char_in),
        .format_type(format_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each character is driven on a falling edge with its expectation pushed;
    // the result is popped and compared 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [1:0] want;
            string      nm;
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            total++;
            if (format_type !== want) begin
                bad++;
                $display("FAIL %s: format_type got=%0d want=%0d at t=%0t",
                         nm, format_type, want, $time);
            end
        end
    end

    // Drive a string; every '#' expects cls, every other character expects 0.
    task automatic send_line(input string nm, input string s, input logic [1:0] cls);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            @(negedge clk);
            char_in = c;
            exp_q.push_back((c == 8'h23) ? cls : 2'd0);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic send_idle(input string nm);
        @(negedge clk);
        char_in = 8'h20;
        exp_q.push_back(2'd0);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        char_in = 8'h20;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (format_type !== 2'd0) begin
            bad++;
            $display("FAIL reset_value: format_type got=%0d want=0", format_type);
        end
        @(negedge clk);
        reset = 1'b1;
        // A '#' straight out of reset must not produce a record.
        send_line("reset_hash", "#", 2'd0);
    endtask

    task automatic test_reg_record;
        send_line("reg_basic", "^242@000030f4: $31 <=12345678#", 2'd1);
        send_idle("reg_pulse_width");
        send_line("reg_no_spaces", "^1@0000000a:$5<=deadbeef#", 2'd1);
        send_idle("reg_no_spaces_after");
        send_line("reg_4dig", "^1234@abcdef01: $1234   <=   00000000#", 2'd1);
    endtask

    task automatic test_mem_record;
        send_line("mem_basic", "^338@00003130: *00000088 <= ffffb528#", 2'd2);
        send_idle("mem_pulse_width");
        send_line("mem_upper0", "^338@00003130: *00000088 <= Ffffb528#", 2'd0);
        send_line("mem_upper4", "^338@00003130: *00000088 <= ffffB528#", 2'd0);
        send_line("mem_upper7", "^338@00003130: *00000088 <= ffffb52B#", 2'd0);
        send_line("mem_upper_pc", "^338@00003A30: *00000088 <= ffffb528#", 2'd0);
        send_line("mem_addr7", "^338@00003130: *0000088 <= ffffb528#", 2'd0);
        send_line("mem_tight", "^9999@abcdef01:*0123abcd<=00000000#", 2'd2);
    endtask

    task automatic test_data_length;
        send_line("data7", "^338@00003130: *00000088 <= fffb528#", 2'd0);
        send_line("data9", "^338@00003130: *00000088 <= fffb52812#", 2'd0);
        send_line("data10", "^338@00003130: *00000088 <= fffb528123#", 2'd0);
        send_line("data_empty", "^242@000030f4: $31 <=#", 2'd0);
        send_line("data_sp_hash", "^242@000030f4: $31 <=   123215 #", 2'd0);
        send_line("data8_sp_hash", "^242@000030f4: $31 <=12345678 #", 2'd0);
        send_line("lt_space_eq", "^242@000030f4: $31 < =12345678#", 2'd0);
    endtask

    task automatic test_digit_limits;
        send_line("time5", "^12345@000030f4: $31 <=12345678#", 2'd0);
        send_line("grf5", "^1@000030f4: $12345 <=12345678#", 2'd0);
        send_line("pc9", "^1@000030f45: $3 <=12345678#", 2'd0);
        send_line("time0", "^@000030f4: $31 <=12345678#", 2'd0);
    endtask

    task automatic test_restart;
        send_line("restart", "^24^242@000030f4: $31 <=12345678#", 2'd1);
        send_line("restart_data", "^1@00000000: $1 <=1234^2@00000000: *00000000 <=aaaaaaaa#", 2'd2);
    endtask

    task automatic test_back_to_back;
        send_line("b2b_reg", "^1@00000001: $1 <=00000001#^2@00000002: $2 <=00000002#", 2'd1);
        send_line("b2b_mem", "^3@00000003: *00000003 <=00000003#", 2'd2);
        send_line("b2b_reg2", "^4@00000004: $4 <=00000004#", 2'd1);
        send_idle("b2b_after");
    endtask

    task automatic test_reset_midline;
        // Asynchronous clear while a record pulse is showing.
        send_line("async_pre", "^5@00000005: $5 <=00000005#", 2'd1);
        reset = 1'b0;
        #1;
        total++;
        if (format_type !== 2'd0) begin
            bad++;
            $display("FAIL async_clear: format_type got=%0d want=0", format_type);
        end
        @(negedge clk);
        reset = 1'b1;
        // Reset partway through a line discards it.
        send_line("mid_part1", "^242@000030f4: $3", 2'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send_line("mid_rest", "1 <=12345678#", 2'd0);
        send_line("mid_full", "^242@000030f4: $31 <=12345678#", 2'd1);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        char_in = 8'h20;
        test_reset();
        test_reg_record();
        test_mem_record();
        test_data_length();
        test_digit_limits();
        test_restart();
        test_back_to_back();
        test_reset_midline();
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: finished got=0 want=1");
        $fatal(1, "timeout");
    end

endmodule
